// File: rtl/vector_bypass_pipeline.sv
// Tracks in-flight vector register writes and forwards their data, per lane,
// into register-file reads. Entry 0 is the newest write and wins per lane.
module vector_bypass_pipeline #(
  parameter int unsigned LANES         = 16,
  parameter int unsigned LANE_WIDTH    = 32,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned READ_PORTS    = 2,
  parameter int unsigned REG_IDX_WIDTH = 7,
  parameter int unsigned REG_OUT       = 0,
  localparam int unsigned V            = LANES * LANE_WIDTH,
  localparam int unsigned OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                advance_i,
  input  logic                                flush_i,
  input  logic                                wb_write_i,
  input  logic [REG_IDX_WIDTH-1:0]            wb_register_i,
  input  logic [LANES-1:0]                    wb_mask_i,
  input  logic [V-1:0]                        wb_value_i,
  input  logic [READ_PORTS*REG_IDX_WIDTH-1:0] read_sel_i,
  input  logic [READ_PORTS*V-1:0]             read_data_i,
  output logic [READ_PORTS*V-1:0]             read_value_o,
  output logic [READ_PORTS-1:0]               read_pending_o,
  output logic [OCC_W-1:0]                    occupancy_o
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [REG_IDX_WIDTH-1:0] reg_q   [DEPTH];
  logic [LANES-1:0]         mask_q  [DEPTH];
  logic [V-1:0]             value_q [DEPTH];

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (advance_i) begin
      valid_d[0] = wb_write_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload fields need no reset: they are only observed through valid bits.
  always_ff @(posedge clk) begin
    if (advance_i && !flush_i) begin
      reg_q[0]   <= wb_register_i;
      mask_q[0]  <= wb_mask_i;
      value_q[0] <= wb_value_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        reg_q[k]   <= reg_q[k-1];
        mask_q[k]  <= mask_q[k-1];
        value_q[k] <= value_q[k-1];
      end
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
    end
  end

  logic [READ_PORTS*V-1:0] value_c;
  logic [READ_PORTS-1:0]   pending_c;

  // Scan oldest to newest so the newest matching entry overwrites each lane last.
  always_comb begin
    value_c   = read_data_i;
    pending_c = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (valid_q[k] && reg_q[k] == read_sel_i[p*REG_IDX_WIDTH +: REG_IDX_WIDTH]) begin
          if (|mask_q[k]) begin
            pending_c[p] = 1'b1;
          end
          for (int unsigned l = 0; l < LANES; l++) begin
            if (mask_q[k][l]) begin
              value_c[p*V + l*LANE_WIDTH +: LANE_WIDTH] = value_q[k][l*LANE_WIDTH +: LANE_WIDTH];
            end
          end
        end
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        read_value_o   <= '0;
        read_pending_o <= '0;
      end else begin
        read_value_o   <= value_c;
        read_pending_o <= pending_c;
      end
    end
  end else begin : g_comb_out
    assign read_value_o   = value_c;
    assign read_pending_o = pending_c;
  end

endmodule

// File: tb/tb_vector_bypass_pipeline.sv
// Directed bench: a combinational-output and a registered-output instance share stimulus.
module tb_vector_bypass_pipeline;

  localparam int unsigned LANES = 16;
  localparam int unsigned LW    = 32;
  localparam int unsigned V     = LANES * LW;
  localparam int unsigned RP    = 2;
  localparam int unsigned RW    = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            advance_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            wb_write_i = 1'b0;
  logic [RW-1:0]   wb_register_i = '0;
  logic [LANES-1:0] wb_mask_i = '0;
  logic [V-1:0]    wb_value_i = '0;
  logic [RP*RW-1:0] read_sel_i = '0;
  logic [RP*V-1:0] read_data_i = '0;

  logic [RP*V-1:0] c_value, r_value;
  logic [RP-1:0]   c_pending, r_pending;
  logic [2:0]      c_occ, r_occ;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_bypass_pipeline #(.DEPTH(4), .REG_OUT(0)) dut_c (
    .clk(clk), .reset(reset), .advance_i(advance_i), .flush_i(flush_i),
    .wb_write_i(wb_write_i), .wb_register_i(wb_register_i), .wb_mask_i(wb_mask_i),
    .wb_value_i(wb_value_i), .read_sel_i(read_sel_i), .read_data_i(read_data_i),
    .read_value_o(c_value), .read_pending_o(c_pending), .occupancy_o(c_occ)
  );

  vector_bypass_pipeline #(.DEPTH(4), .REG_OUT(1)) dut_r (
    .clk(clk), .reset(reset), .advance_i(advance_i), .flush_i(flush_i),
    .wb_write_i(wb_write_i), .wb_register_i(wb_register_i), .wb_mask_i(wb_mask_i),
    .wb_value_i(wb_value_i), .read_sel_i(read_sel_i), .read_data_i(read_data_i),
    .read_value_o(r_value), .read_pending_o(r_pending), .occupancy_o(r_occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input logic [RP*V-1:0] vec, input int p, input int l);
    return vec[p*V + l*LW +: LW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic wr, input logic [RW-1:0] r, input logic [LANES-1:0] m,
                           input logic [31:0] base);
    wb_write_i    = wr;
    wb_register_i = r;
    wb_mask_i     = m;
    for (int l = 0; l < LANES; l++) wb_value_i[l*LW +: LW] = base + 32'(l);
  endtask

  task automatic set_sel(input logic [RW-1:0] s0, input logic [RW-1:0] s1);
    read_sel_i = {s1, s0};
  endtask

  initial begin
    for (int l = 0; l < LANES; l++) begin
      read_data_i[l*LW +: LW]     = 32'h11 + 32'(l);
      read_data_i[V + l*LW +: LW] = 32'h2000 + 32'(l);
    end
    set_sel(7'd5, 7'd3);
    #2 reset = 1'b0;
    #1;
    check("rst_c_lane0", 64'(lane_of(c_value, 0, 0)), 64'h11);
    check("rst_c_pending", 64'(c_pending), 64'h0);
    check("rst_c_occ", 64'(c_occ), 64'h0);
    check("rst_r_value_zero", 64'(r_value == '0), 64'h1);
    check("rst_r_pending", 64'(r_pending), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Two writes to r5; the newer covers lanes 0 and 1.
    advance_i = 1'b1;
    set_write(1'b1, 7'd5, 16'h0001, 32'h0000AAAA);
    step();
    set_write(1'b1, 7'd5, 16'h0003, 32'h0000BBBB);
    step();
    advance_i = 1'b0;
    set_write(1'b0, 7'd0, 16'h0000, 32'h0);
    #1;
    check("nw_lane0", 64'(lane_of(c_value, 0, 0)), 64'hBBBB);
    check("nw_lane1", 64'(lane_of(c_value, 0, 1)), 64'hBBBC);
    check("nw_lane2", 64'(lane_of(c_value, 0, 2)), 64'h13);
    check("nw_occ", 64'(c_occ), 64'h2);
    check("nw_pending", 64'(c_pending), 64'b01);
    set_sel(7'd5, 7'd5);
    #1;
    check("nw_p1_lane1", 64'(lane_of(c_value, 1, 1)), 64'hBBBC);
    check("nw_p1_lane2", 64'(lane_of(c_value, 1, 2)), 64'h2002);
    check("nw_pending_both", 64'(c_pending), 64'b11);

    // Stall: writes offered but ignored.
    set_write(1'b1, 7'd5, 16'hFFFF, 32'h0000DDDD);
    repeat (3) step();
    check("stall_occ", 64'(c_occ), 64'h2);
    check("stall_lane0", 64'(lane_of(c_value, 0, 0)), 64'hBBBB);
    check("stall_lane5", 64'(lane_of(c_value, 0, 5)), 64'h16);

    // Flush with advance: incoming write dropped.
    flush_i   = 1'b1;
    advance_i = 1'b1;
    step();
    flush_i   = 1'b0;
    advance_i = 1'b0;
    set_write(1'b0, 7'd0, 16'h0000, 32'h0);
    #1;
    check("flush_occ", 64'(c_occ), 64'h0);
    check("flush_pending", 64'(c_pending), 64'h0);
    check("flush_lane0", 64'(lane_of(c_value, 0, 0)), 64'h11);

    // Single write retires after DEPTH further advances.
    set_sel(7'd5, 7'd3);
    advance_i = 1'b1;
    set_write(1'b1, 7'd5, 16'h0001, 32'h00001234);
    step();
    set_write(1'b0, 7'd0, 16'h0000, 32'h0);
    repeat (3) step();
    check("age3_lane0", 64'(lane_of(c_value, 0, 0)), 64'h1234);
    check("age3_occ", 64'(c_occ), 64'h1);
    step();
    check("age4_lane0", 64'(lane_of(c_value, 0, 0)), 64'h11);
    check("age4_occ", 64'(c_occ), 64'h0);
    check("age4_pending", 64'(c_pending), 64'h0);

    // Zero-mask write occupies a slot but never forwards.
    set_sel(7'd7, 7'd3);
    set_write(1'b1, 7'd7, 16'h0000, 32'h0000EEEE);
    step();
    advance_i = 1'b0;
    set_write(1'b0, 7'd0, 16'h0000, 32'h0);
    #1;
    check("zm_occ", 64'(c_occ), 64'h1);
    check("zm_lane0", 64'(lane_of(c_value, 0, 0)), 64'h11);
    check("zm_lane5", 64'(lane_of(c_value, 0, 5)), 64'h16);
    check("zm_pending", 64'(c_pending), 64'h0);

    // Registered outputs: r9 in lanes 0 and 15.
    advance_i = 1'b1;
    set_write(1'b1, 7'd9, 16'h8001, 32'h00009000);
    step();
    advance_i = 1'b0;
    set_write(1'b0, 7'd0, 16'h0000, 32'h0);
    check("ro_occ", 64'(r_occ), 64'h2);
    set_sel(7'd9, 7'd3);
    step();
    check("ro_p0_lane0", 64'(lane_of(r_value, 0, 0)), 64'h9000);
    check("ro_p0_lane15", 64'(lane_of(r_value, 0, 15)), 64'h900F);
    check("ro_p0_lane1", 64'(lane_of(r_value, 0, 1)), 64'h12);
    check("ro_p1_lane0", 64'(lane_of(r_value, 1, 0)), 64'h2000);
    check("ro_pending", 64'(r_pending), 64'b01);
    set_sel(7'd3, 7'd3);
    #1;
    check("ro_hold_lane0", 64'(lane_of(r_value, 0, 0)), 64'h9000);
    check("ro_hold_pending", 64'(r_pending), 64'b01);
    step();
    check("ro_upd_lane0", 64'(lane_of(r_value, 0, 0)), 64'h11);
    check("ro_upd_pending", 64'(r_pending), 64'b00);

    // Reset mid-operation discards tracked writes immediately.
    set_sel(7'd9, 7'd9);
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_c_occ", 64'(c_occ), 64'h0);
    check("mid_rst_c_pending", 64'(c_pending), 64'h0);
    check("mid_rst_r_pending", 64'(r_pending), 64'h0);
    check("mid_rst_r_value_zero", 64'(r_value == '0), 64'h1);
    reset = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
